// File: rtl/exmem_skid_stage.sv
// EX/MEM two-entry skid stage with load/store lane steering and redirect decode.
// in_ready is registered so upstream never sees a combinational path from out_ready.
module exmem_skid_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [2:0]        in_funct3,
    input  logic [2:0]        in_kind,
    input  logic              in_cmp,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_alu,
    output logic [XLEN-1:0]   out_pc,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [2:0]        out_kind,
    output logic [2:0]        out_funct3,
    output logic [XLEN/8-1:0] out_mbe,
    output logic [XLEN-1:0]   out_wdata,
    output logic              out_misalign,
    output logic              out_redirect,
    output logic [XLEN-1:0]   out_target,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int MB = XLEN / 8;
    localparam int OW = $clog2(MB);

    localparam logic [2:0] K_LOAD   = 3'd1;
    localparam logic [2:0] K_STORE  = 3'd2;
    localparam logic [2:0] K_BRANCH = 3'd3;
    localparam logic [2:0] K_JAL    = 3'd4;
    localparam logic [2:0] K_JALR   = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   rs2;
        logic [XLEN-1:0]   pc;
        logic [2:0]        funct3;
        logic [2:0]        kind;
        logic              cmp;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    entry_t r_head, r_skid, w_in;
    logic   r_head_v, r_skid_v, r_in_ready;
    logic   w_acc, w_pop, w_head_v_nxt, w_skid_v_nxt;

    assign w_in  = '{alu: in_alu, rs2: in_rs2, pc: in_pc,
                     funct3: in_funct3, kind: in_kind,
                     cmp: in_cmp, ctrl: in_ctrl};
    assign w_acc = in_valid && r_in_ready;
    assign w_pop = r_head_v && out_ready;

    always_comb begin
        w_head_v_nxt = r_head_v;
        w_skid_v_nxt = r_skid_v;
        if (flush) begin
            w_head_v_nxt = 1'b0;
            w_skid_v_nxt = 1'b0;
        end else begin
            case ({r_head_v, r_skid_v})
                2'b00: if (w_acc) w_head_v_nxt = 1'b1;
                2'b10: begin
                    if (w_acc && !w_pop)
                        w_skid_v_nxt = 1'b1;
                    else if (!w_acc && w_pop)
                        w_head_v_nxt = 1'b0;
                end
                2'b11: if (w_pop) w_skid_v_nxt = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b1;
            r_head     <= '0;
            r_skid     <= '0;
            stall_cnt  <= '0;
        end else begin
            r_head_v   <= w_head_v_nxt;
            r_skid_v   <= w_skid_v_nxt;
            r_in_ready <= !w_skid_v_nxt;
            if (!flush) begin
                if (w_pop && r_skid_v)
                    r_head <= r_skid;
                else if (w_acc && (!r_head_v || w_pop))
                    r_head <= w_in;
                if (w_acc && r_head_v && !w_pop)
                    r_skid <= w_in;
                if (r_head_v && !out_ready && !(&stall_cnt))
                    stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_head_v;
    assign out_alu    = r_head.alu;
    assign out_pc     = r_head.pc;
    assign out_ctrl   = r_head.ctrl;
    assign out_kind   = r_head.kind;
    assign out_funct3 = r_head.funct3;

    logic [OW-1:0] w_off, w_alm;
    logic [MB-1:0] w_mask;
    logic          w_is_ls, w_bad;

    assign w_off   = r_head.alu[OW-1:0];
    assign w_is_ls = (r_head.kind == K_LOAD) || (r_head.kind == K_STORE);

    always_comb begin
        case (r_head.funct3[1:0])
            2'd0:    begin w_mask = MB'(8'h01); w_alm = OW'(0); end
            2'd1:    begin w_mask = MB'(8'h03); w_alm = OW'(1); end
            2'd2:    begin w_mask = MB'(8'h0F); w_alm = OW'(3); end
            default: begin w_mask = MB'(8'hFF); w_alm = OW'(7); end
        endcase
        // Doubleword access has no legal encoding on a 32-bit datapath
        w_bad = ((r_head.funct3[1:0] == 2'd3) && (XLEN == 32))
             || ((w_off & w_alm) != '0);
    end

    always_comb begin
        out_mbe      = '0;
        out_wdata    = '0;
        out_misalign = 1'b0;
        out_redirect = 1'b0;
        out_target   = '0;
        if (r_head_v) begin
            if (w_is_ls)
                out_mbe = w_bad ? '0 : (w_mask << w_off);
            else
                out_mbe = '1;
            out_misalign = w_is_ls && w_bad;
            out_wdata = (r_head.kind == K_STORE)
                      ? (r_head.rs2 << {w_off, 3'b000}) : r_head.rs2;
            if (r_head.kind == K_BRANCH)
                out_redirect = r_head.cmp;
            else
                out_redirect = (r_head.kind == K_JAL) || (r_head.kind == K_JALR);
            out_target = {r_head.alu[XLEN-1:1],
                          r_head.alu[0] && (r_head.kind != K_JALR)};
        end
    end
endmodule

// File: tb/tb_exmem_skid_stage.sv
// Directed bench for exmem_skid_stage: lane steering, skid flow, flush, reset.
module tb_exmem_skid_stage;
    localparam logic [2:0] K_OTH = 3'd0, K_LD = 3'd1, K_ST = 3'd2;
    localparam logic [2:0] K_BR = 3'd3, K_JAL = 3'd4, K_JALR = 3'd5;

    int nchk = 0;
    int nfail = 0;

    logic        clk, rst, flush;
    logic        in_valid, in_ready, in_cmp, out_valid, out_ready;
    logic [31:0] in_alu, in_rs2, in_pc, out_alu, out_pc, out_wdata, out_target;
    logic [2:0]  in_funct3, in_kind, out_kind, out_funct3;
    logic [63:0] in_ctrl, out_ctrl;
    logic [3:0]  out_mbe;
    logic        out_misalign, out_redirect;
    logic [31:0] stall_cnt;

    logic        d_in_valid, d_in_ready, d_in_cmp, d_out_valid, d_out_ready;
    logic [63:0] d_in_alu, d_in_rs2, d_in_pc, d_out_alu, d_out_pc;
    logic [63:0] d_out_wdata, d_out_target, d_in_ctrl, d_out_ctrl;
    logic [2:0]  d_in_funct3, d_in_kind, d_out_kind, d_out_funct3;
    logic [7:0]  d_out_mbe;
    logic        d_out_misalign, d_out_redirect;
    logic [31:0] d_stall_cnt;

    exmem_skid_stage #(.XLEN(32)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_alu(in_alu), .in_rs2(in_rs2), .in_pc(in_pc),
        .in_funct3(in_funct3), .in_kind(in_kind), .in_cmp(in_cmp),
        .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_alu(out_alu), .out_pc(out_pc),
        .out_ctrl(out_ctrl), .out_kind(out_kind), .out_funct3(out_funct3),
        .out_mbe(out_mbe), .out_wdata(out_wdata),
        .out_misalign(out_misalign), .out_redirect(out_redirect),
        .out_target(out_target), .stall_cnt(stall_cnt)
    );

    exmem_skid_stage #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_alu(d_in_alu), .in_rs2(d_in_rs2), .in_pc(d_in_pc),
        .in_funct3(d_in_funct3), .in_kind(d_in_kind), .in_cmp(d_in_cmp),
        .in_ctrl(d_in_ctrl), .flush(flush), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .out_alu(d_out_alu), .out_pc(d_out_pc),
        .out_ctrl(d_out_ctrl), .out_kind(d_out_kind),
        .out_funct3(d_out_funct3), .out_mbe(d_out_mbe),
        .out_wdata(d_out_wdata), .out_misalign(d_out_misalign),
        .out_redirect(d_out_redirect), .out_target(d_out_target),
        .stall_cnt(d_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] k, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] r,
                        input logic c, input logic [63:0] ct);
        in_valid = 1'b1; in_kind = k; in_funct3 = f;
        in_alu = a; in_rs2 = r; in_cmp = c; in_ctrl = ct;
        in_pc = a + 32'h100;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        d_in_valid = 1'b0; d_out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        nchk++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        nchk++; if (stall_cnt !== 32'd0) begin nfail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
        nchk++; if (out_mbe !== 4'h0) begin nfail++; $display("FAIL reset_mbe: got %h want 0", out_mbe); end
    endtask

    task automatic test_store_sh();
        do_reset();
        send(K_ST, 3'd1, 32'h1002, 32'h0000ABCD, 1'b0, 64'h5);
        tick();
        in_valid = 1'b0;
        nchk++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL sh_valid: got %b want 1", out_valid); end
        nchk++; if (out_mbe !== 4'b1100) begin nfail++; $display("FAIL sh_mbe: got %b want 1100", out_mbe); end
        nchk++; if (out_wdata !== 32'hABCD0000) begin nfail++; $display("FAIL sh_wdata: got %h want abcd0000", out_wdata); end
        nchk++; if (out_misalign !== 1'b0) begin nfail++; $display("FAIL sh_misalign: got %b want 0", out_misalign); end
        nchk++; if (out_pc !== 32'h1102) begin nfail++; $display("FAIL sh_pc: got %h want 1102", out_pc); end
        out_ready = 1'b1;
        tick();
        nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL sh_pop: got %b want 0", out_valid); end
    endtask

    task automatic test_load();
        do_reset();
        send(K_LD, 3'd2, 32'h1001, 32'h12, 1'b0, 64'h0);
        tick();
        nchk++; if (out_mbe !== 4'h0) begin nfail++; $display("FAIL lw_mis_mbe: got %b want 0000", out_mbe); end
        nchk++; if (out_misalign !== 1'b1) begin nfail++; $display("FAIL lw_mis: got %b want 1", out_misalign); end
        out_ready = 1'b1;
        send(K_LD, 3'd4, 32'h1003, 32'h12, 1'b0, 64'h0);
        tick();
        nchk++; if (out_mbe !== 4'b1000) begin nfail++; $display("FAIL lbu_mbe: got %b want 1000", out_mbe); end
        nchk++; if (out_wdata !== 32'h12) begin nfail++; $display("FAIL lbu_wdata: got %h want 12", out_wdata); end
        nchk++; if (out_misalign !== 1'b0) begin nfail++; $display("FAIL lbu_mis: got %b want 0", out_misalign); end
        send(K_LD, 3'd3, 32'h1000, 32'h0, 1'b0, 64'h0);
        tick();
        in_valid = 1'b0;
        nchk++; if (out_misalign !== 1'b1 || out_mbe !== 4'h0) begin nfail++; $display("FAIL ld32: got mis=%b mbe=%b want mis=1 mbe=0000", out_misalign, out_mbe); end
    endtask

    task automatic test_xlen64();
        do_reset();
        d_in_valid = 1'b1; d_in_kind = K_ST; d_in_funct3 = 3'd3;
        d_in_alu = 64'h8; d_in_rs2 = 64'h1122334455667788;
        d_in_pc = 64'h0; d_in_cmp = 1'b0; d_in_ctrl = 64'h0;
        tick();
        nchk++; if (d_out_mbe !== 8'hFF) begin nfail++; $display("FAIL sd_mbe: got %h want ff", d_out_mbe); end
        nchk++; if (d_out_wdata !== 64'h1122334455667788) begin nfail++; $display("FAIL sd_wdata: got %h want 1122334455667788", d_out_wdata); end
        d_out_ready = 1'b1;
        d_in_funct3 = 3'd2; d_in_alu = 64'h4; d_in_rs2 = 64'hDEADBEEF;
        tick();
        d_in_valid = 1'b0;
        nchk++; if (d_out_mbe !== 8'hF0) begin nfail++; $display("FAIL sw64_mbe: got %h want f0", d_out_mbe); end
        nchk++; if (d_out_wdata !== 64'hDEADBEEF00000000) begin nfail++; $display("FAIL sw64_wdata: got %h want deadbeef00000000", d_out_wdata); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(K_OTH, 3'd0, 32'hA, 32'h0, 1'b0, 64'hA1);
        tick();
        nchk++; if (in_ready !== 1'b1 || stall_cnt !== 32'd0) begin nfail++; $display("FAIL b2b_c1: got rdy=%b cnt=%0d want rdy=1 cnt=0", in_ready, stall_cnt); end
        send(K_OTH, 3'd0, 32'hB, 32'h0, 1'b0, 64'hB2);
        tick();
        nchk++; if (in_ready !== 1'b0 || stall_cnt !== 32'd1) begin nfail++; $display("FAIL b2b_c2: got rdy=%b cnt=%0d want rdy=0 cnt=1", in_ready, stall_cnt); end
        send(K_OTH, 3'd0, 32'hC, 32'h0, 1'b0, 64'hC3);
        tick();
        in_valid = 1'b0;
        nchk++; if (stall_cnt !== 32'd2) begin nfail++; $display("FAIL b2b_stall: got %0d want 2", stall_cnt); end
        nchk++; if (out_alu !== 32'hA || out_mbe !== 4'hF) begin nfail++; $display("FAIL b2b_head: got alu=%h mbe=%h want alu=a mbe=f", out_alu, out_mbe); end
        out_ready = 1'b1;
        tick();
        nchk++; if (out_alu !== 32'hB || out_ctrl !== 64'hB2) begin nfail++; $display("FAIL b2b_second: got alu=%h ctrl=%h want b / b2", out_alu, out_ctrl); end
        nchk++; if (in_ready !== 1'b1 || stall_cnt !== 32'd2) begin nfail++; $display("FAIL b2b_drain: got rdy=%b cnt=%0d want rdy=1 cnt=2", in_ready, stall_cnt); end
        tick();
        nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        send(K_OTH, 3'd0, 32'h1, 32'h0, 1'b0, 64'h0);
        tick();
        send(K_OTH, 3'd0, 32'h2, 32'h0, 1'b0, 64'h0);
        tick();
        flush = 1'b1; out_ready = 1'b1;
        send(K_OTH, 3'd0, 32'h3, 32'h0, 1'b0, 64'h0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        nchk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin nfail++; $display("FAIL flush_two: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        nchk++; if (stall_cnt !== 32'd1) begin nfail++; $display("FAIL flush_cnt: got %0d want 1", stall_cnt); end
        tick();
        nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL flush_no_emit: got %b want 0", out_valid); end
        send(K_OTH, 3'd0, 32'h4, 32'h0, 1'b0, 64'h0);
        tick();
        flush = 1'b1;
        send(K_OTH, 3'd0, 32'h5, 32'h0, 1'b0, 64'h0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL flush_one: got %b want 0", out_valid); end
    endtask

    task automatic test_redirect();
        do_reset();
        out_ready = 1'b1;
        send(K_JALR, 3'd0, 32'h2003, 32'h0, 1'b0, 64'h0);
        tick();
        nchk++; if (out_redirect !== 1'b1 || out_target !== 32'h2002) begin nfail++; $display("FAIL jalr: got r=%b t=%h want r=1 t=2002", out_redirect, out_target); end
        send(K_BR, 3'd0, 32'h3000, 32'h0, 1'b0, 64'h0);
        tick();
        nchk++; if (out_redirect !== 1'b0) begin nfail++; $display("FAIL br_nt: got %b want 0", out_redirect); end
        send(K_BR, 3'd0, 32'h3010, 32'h0, 1'b1, 64'h0);
        tick();
        nchk++; if (out_redirect !== 1'b1 || out_target !== 32'h3010) begin nfail++; $display("FAIL br_t: got r=%b t=%h want r=1 t=3010", out_redirect, out_target); end
        send(K_JAL, 3'd0, 32'h4001, 32'h0, 1'b0, 64'h0);
        tick();
        in_valid = 1'b0;
        nchk++; if (out_redirect !== 1'b1 || out_target !== 32'h4001) begin nfail++; $display("FAIL jal: got r=%b t=%h want r=1 t=4001", out_redirect, out_target); end
        tick();
        nchk++; if (out_redirect !== 1'b0 || out_target !== 32'h0) begin nfail++; $display("FAIL idle_redirect: got r=%b t=%h want 0 0", out_redirect, out_target); end
    endtask

    task automatic test_reset_two();
        do_reset();
        send(K_OTH, 3'd0, 32'h7, 32'h0, 1'b0, 64'h0);
        tick();
        send(K_OTH, 3'd0, 32'h8, 32'h0, 1'b0, 64'h0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        nchk++; if (stall_cnt !== 32'd5) begin nfail++; $display("FAIL pre_rst_cnt: got %0d want 5", stall_cnt); end
        rst = 1'b1;
        tick();
        nchk++; if (out_valid !== 1'b0 || stall_cnt !== 32'd0) begin nfail++; $display("FAIL rst_two: got v=%b cnt=%0d want v=0 cnt=0", out_valid, stall_cnt); end
        nchk++; if (out_alu !== 32'h0) begin nfail++; $display("FAIL rst_fields: got %h want 0", out_alu); end
        rst = 1'b0;
        tick();
        nchk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin nfail++; $display("FAIL rst_after: got rdy=%b v=%b want 1 0", in_ready, out_valid); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_alu = '0; in_rs2 = '0; in_pc = '0; in_funct3 = '0;
        in_kind = '0; in_cmp = 1'b0; in_ctrl = '0;
        d_in_valid = 1'b0; d_out_ready = 1'b0; d_in_alu = '0;
        d_in_rs2 = '0; d_in_pc = '0; d_in_funct3 = '0;
        d_in_kind = '0; d_in_cmp = 1'b0; d_in_ctrl = '0;
        test_reset();
        test_store_sh();
        test_load();
        test_xlen64();
        test_back_to_back();
        test_flush();
        test_redirect();
        test_reset_two();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
